// File: rtl/dkong3_objram_arb_pkg.sv
// dkong3_objarb_pkg: shared types and widths for the object RAM arbiter
package dkong3_objarb_pkg;
    localparam int OBJ_AW = 10;
    localparam int OBJ_DW = 8;
    typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_CPU, GNT_DMA} gnt_e;
endpackage

// File: rtl/dkong3_objram_arb_if.sv
// dkong3_objram_arb_if: video, DMA, CPU and RAM-side signals of the object RAM arbiter
interface dkong3_objram_arb_if #(parameter int LVL_W = 3);
    import dkong3_objarb_pkg::*;
    logic              I_VID_REQ;
    logic [OBJ_AW-1:0] I_VID_A;
    logic [OBJ_DW-1:0] O_VID_D;
    logic              O_VID_ACK;
    logic              I_DMA_CE;
    logic              I_DMA_WE;
    logic [OBJ_AW-1:0] I_DMA_A;
    logic [OBJ_DW-1:0] I_DMA_D;
    logic              I_CPU_RQ_n;
    logic              I_CPU_RD_n;
    logic              I_CPU_WR_n;
    logic [OBJ_AW-1:0] I_CPU_A;
    logic [OBJ_DW-1:0] I_CPU_D;
    logic [OBJ_DW-1:0] O_CPU_D;
    logic              O_WAIT_n;
    logic              O_RAM_CE;
    logic              O_RAM_WE;
    logic [OBJ_AW-1:0] O_RAM_A;
    logic [OBJ_DW-1:0] O_RAM_D;
    logic [OBJ_DW-1:0] I_RAM_Q;
    logic [LVL_W-1:0]  O_FIFO_LVL;
    logic              O_OVF;
    modport slave (
        input  I_VID_REQ, I_VID_A, I_DMA_CE, I_DMA_WE, I_DMA_A, I_DMA_D,
               I_CPU_RQ_n, I_CPU_RD_n, I_CPU_WR_n, I_CPU_A, I_CPU_D, I_RAM_Q,
        output O_VID_D, O_VID_ACK, O_CPU_D, O_WAIT_n, O_RAM_CE, O_RAM_WE,
               O_RAM_A, O_RAM_D, O_FIFO_LVL, O_OVF
    );
    modport master (
        output I_VID_REQ, I_VID_A, I_DMA_CE, I_DMA_WE, I_DMA_A, I_DMA_D,
               I_CPU_RQ_n, I_CPU_RD_n, I_CPU_WR_n, I_CPU_A, I_CPU_D, I_RAM_Q,
        input  O_VID_D, O_VID_ACK, O_CPU_D, O_WAIT_n, O_RAM_CE, O_RAM_WE,
               O_RAM_A, O_RAM_D, O_FIFO_LVL, O_OVF
    );
endinterface

// File: rtl/dkong3_objram_arb_fifo.sv
// dkong3_objarb_fifo: posted DMA write queue; full pushes without a pop are dropped and flagged
module dkong3_objarb_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 18,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [LW-1:0] lvl_o,
    output logic          ovf_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          ovf_q, ovf_d, full, wr, rd;
    // pointer/level update; a pop frees the slot a same-cycle push into a full queue needs
    always_comb begin
        full  = lvl_q == LW'(DEPTH);
        rd    = pop_i && lvl_q != '0;
        wr    = push_i && (!full || rd);
        wp_d  = wp_q + AW'(wr);
        rp_d  = rp_q + AW'(rd);
        lvl_d = lvl_q + LW'(wr) - LW'(rd);
        ovf_d = ovf_q || (push_i && !wr);
    end
    // control state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
        end
    end
    // storage needs no reset; the level guards every read
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wp_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rp_q];
    assign lvl_o   = lvl_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/dkong3_objram_arb.sv
// dkong3_objram_arb: one-slot-per-clock arbiter for the object RAM between video, CPU and DMA
module dkong3_objram_arb
    import dkong3_objarb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HI_WM = 3,
    parameter int MAX_WAIT = 8
) (
    input logic I_CLK,
    input logic I_RESET_n,
    dkong3_objram_arb_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [LW-1:0] HI = LW'(HI_WM);
    localparam logic [CW-1:0] MW = CW'(MAX_WAIT);
    gnt_e                     gnt, tag1_q, tag1_d, tag2_q;
    logic [CW-1:0]            wcnt_q, wcnt_d;
    logic                     served_q, served_d, cpu_active, cpu_wr, vid_ok, cpu_ok;
    logic                     ram_ce_q, ram_ce_d, ram_we_q, ram_we_d;
    logic [OBJ_AW-1:0]        ram_a_q, ram_a_d;
    logic [OBJ_DW-1:0]        ram_d_q, ram_d_d, vid_d_q, vid_d_d, cpu_d_q, cpu_d_d;
    logic [OBJ_AW+OBJ_DW-1:0] head;
    logic [LW-1:0]            lvl;
    logic                     ovf;

    dkong3_objarb_fifo #(.DEPTH(FIFO_DEPTH), .W(OBJ_AW + OBJ_DW)) u_fifo (
        .clk_i  (I_CLK),
        .rst_ni (I_RESET_n),
        .push_i (bus.I_DMA_CE & bus.I_DMA_WE),
        .pop_i  (gnt == GNT_DMA),
        .wdata_i({bus.I_DMA_A, bus.I_DMA_D}),
        .rdata_o(head),
        .lvl_o  (lvl),
        .ovf_o  (ovf)
    );

    // grant for this slot plus next state of RAM strobes, read pipeline, CPU wait tracking
    always_comb begin
        cpu_wr     = !bus.I_CPU_WR_n;
        cpu_active = !bus.I_CPU_RQ_n && (!bus.I_CPU_RD_n || cpu_wr) && !served_q;
        vid_ok     = bus.I_VID_REQ && tag1_q != GNT_VID && tag2_q != GNT_VID;
        cpu_ok     = cpu_active && tag1_q != GNT_CPU;
        gnt        = vid_ok                 ? GNT_VID :
                     cpu_ok && wcnt_q >= MW ? GNT_CPU :
                     lvl >= HI              ? GNT_DMA :
                     cpu_ok                 ? GNT_CPU :
                     lvl != '0              ? GNT_DMA : GNT_NONE;
        ram_ce_d   = gnt != GNT_NONE;
        ram_we_d   = gnt == GNT_DMA || (gnt == GNT_CPU && cpu_wr);
        ram_a_d    = gnt == GNT_VID ? bus.I_VID_A :
                     gnt == GNT_CPU ? bus.I_CPU_A :
                     gnt == GNT_DMA ? head[OBJ_AW+OBJ_DW-1:OBJ_DW] : '0;
        ram_d_d    = gnt == GNT_CPU ? bus.I_CPU_D :
                     gnt == GNT_DMA ? head[OBJ_DW-1:0] : '0;
        tag1_d     = (gnt == GNT_VID || (gnt == GNT_CPU && !cpu_wr)) ? gnt : GNT_NONE;
        vid_d_d    = tag1_q == GNT_VID ? bus.I_RAM_Q : '0;
        cpu_d_d    = tag1_q == GNT_CPU ? bus.I_RAM_Q : bus.I_CPU_RQ_n ? '0 : cpu_d_q;
        served_d   = !bus.I_CPU_RQ_n && (served_q || (gnt == GNT_CPU && cpu_wr) || tag1_q == GNT_CPU);
        wcnt_d     = gnt == GNT_CPU           ? '0 :
                     cpu_ok && wcnt_q != MW   ? wcnt_q + CW'(1) : wcnt_q;
    end

    // registered state; reset drops any read in flight so no ACK or CPU data follows
    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            ram_ce_q <= 1'b0;
            ram_we_q <= 1'b0;
            ram_a_q  <= '0;
            ram_d_q  <= '0;
            tag1_q   <= GNT_NONE;
            tag2_q   <= GNT_NONE;
            vid_d_q  <= '0;
            cpu_d_q  <= '0;
            served_q <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            ram_ce_q <= ram_ce_d;
            ram_we_q <= ram_we_d;
            ram_a_q  <= ram_a_d;
            ram_d_q  <= ram_d_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag1_q;
            vid_d_q  <= vid_d_d;
            cpu_d_q  <= cpu_d_d;
            served_q <= served_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign bus.O_RAM_CE   = ram_ce_q;
    assign bus.O_RAM_WE   = ram_we_q;
    assign bus.O_RAM_A    = ram_a_q;
    assign bus.O_RAM_D    = ram_d_q;
    assign bus.O_VID_D    = vid_d_q;
    assign bus.O_VID_ACK  = tag2_q == GNT_VID;
    assign bus.O_CPU_D    = cpu_d_q;
    assign bus.O_WAIT_n   = !cpu_active || !I_RESET_n;
    assign bus.O_FIFO_LVL = lvl;
    assign bus.O_OVF      = ovf;
endmodule

// File: tb/tb_dkong3_objram_arb.sv
// tb_dkong3_objram_arb: directed scoreboard bench for the object RAM arbiter
module tb_dkong3_objram_arb;
    import dkong3_objarb_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dkong3_objram_arb_if bus ();
    dkong3_objram_arb dut (.I_CLK(clk), .I_RESET_n(rst_n), .bus(bus));

    logic [7:0] mem [1024];
    logic       pk_we = 1'b0;
    logic [9:0] pk_a = '0;
    logic [7:0] pk_d = '0;
    // RAM model: async read of the registered address, write on the edge ending the strobe cycle
    always @(posedge clk) begin
        if (pk_we) mem[pk_a] <= pk_d;
        else if (bus.O_RAM_CE && bus.O_RAM_WE) mem[bus.O_RAM_A] <= bus.O_RAM_D;
    end
    assign bus.I_RAM_Q = mem[bus.O_RAM_A];

    int total = 0;
    int bad = 0;
    logic [7:0]  vid_q[$];
    logic [7:0]  cpu_q[$];
    logic [17:0] wr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pk_we = 1'b1;
        pk_a = a;
        pk_d = d;
        nxt();
        pk_we = 1'b0;
    endtask

    task automatic push_dma(input logic en, input logic [9:0] a, input logic [7:0] d);
        bus.I_DMA_CE = en;
        bus.I_DMA_WE = en;
        bus.I_DMA_A = a;
        bus.I_DMA_D = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lvl_exp[9] = '{0, 1, 1, 1, 2, 2, 1, 1, 0};
        int ack_exp[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        int we_exp[9]  = '{0, 0, 1, 1, 0, 1, 1, 0, 1};
        logic [9:0]  ta;
        logic [7:0]  td;
        logic [17:0] e;
        int n;
        bus.I_VID_REQ = 1'b0;
        bus.I_VID_A = '0;
        push_dma(1'b0, '0, '0);
        bus.I_CPU_RQ_n = 1'b1;
        bus.I_CPU_RD_n = 1'b1;
        bus.I_CPU_WR_n = 1'b1;
        bus.I_CPU_A = '0;
        bus.I_CPU_D = '0;
        #3;
        chk("rst_wait", 32'(bus.O_WAIT_n), 1);
        chk("rst_ce", 32'(bus.O_RAM_CE), 0);
        chk("rst_ack", 32'(bus.O_VID_ACK), 0);
        chk("rst_cpud", 32'(bus.O_CPU_D), 0);
        chk("rst_lvl", 32'(bus.O_FIFO_LVL), 0);
        chk("rst_ovf", 32'(bus.O_OVF), 0);
        nxt();
        nxt();
        rst_n = 1'b1;
        poke(10'h012, 8'h5A);
        poke(10'h100, 8'h33);
        poke(10'h200, 8'hC7);
        nxt();

        // uncontended CPU read
        nxt();
        bus.I_CPU_RQ_n = 1'b0;
        bus.I_CPU_RD_n = 1'b0;
        bus.I_CPU_A = 10'h012;
        cpu_q.push_back(8'h5A);
        #2;
        chk("rd_wait_c0", 32'(bus.O_WAIT_n), 0);
        chk("rd_ce_c0", 32'(bus.O_RAM_CE), 0);
        nxt();
        #2;
        chk("rd_wait_c1", 32'(bus.O_WAIT_n), 0);
        chk("rd_ce_c1", 32'(bus.O_RAM_CE), 1);
        chk("rd_we_c1", 32'(bus.O_RAM_WE), 0);
        chk("rd_a_c1", 32'(bus.O_RAM_A), 32'h012);
        nxt();
        #2;
        chk("rd_wait_c2", 32'(bus.O_WAIT_n), 1);
        chk("rd_data_c2", 32'(bus.O_CPU_D), 32'(cpu_q.pop_front()));
        chk("rd_ce_c2", 32'(bus.O_RAM_CE), 0);
        nxt();
        bus.I_CPU_RQ_n = 1'b1;
        bus.I_CPU_RD_n = 1'b1;
        nxt();
        #2;
        chk("rd_data_clr", 32'(bus.O_CPU_D), 0);

        // video and CPU read in the same cycle
        nxt();
        bus.I_VID_REQ = 1'b1;
        bus.I_VID_A = 10'h100;
        bus.I_CPU_RQ_n = 1'b0;
        bus.I_CPU_RD_n = 1'b0;
        bus.I_CPU_A = 10'h200;
        vid_q.push_back(8'h33);
        cpu_q.push_back(8'hC7);
        nxt();
        #2;
        chk("vc_a_c1", 32'(bus.O_RAM_A), 32'h100);
        nxt();
        bus.I_VID_REQ = 1'b0;
        #2;
        chk("vc_a_c2", 32'(bus.O_RAM_A), 32'h200);
        chk("vc_ack_c2", 32'(bus.O_VID_ACK), 1);
        chk("vc_vidd_c2", 32'(bus.O_VID_D), 32'(vid_q.pop_front()));
        chk("vc_wait_c2", 32'(bus.O_WAIT_n), 0);
        nxt();
        #2;
        chk("vc_ack_c3", 32'(bus.O_VID_ACK), 0);
        chk("vc_cpud_c3", 32'(bus.O_CPU_D), 32'(cpu_q.pop_front()));
        chk("vc_wait_c3", 32'(bus.O_WAIT_n), 1);
        nxt();
        bus.I_CPU_RQ_n = 1'b1;
        bus.I_CPU_RD_n = 1'b1;
        repeat (3) nxt();

        // video held continuously while 5 DMA writes arrive
        for (int c = 0; c < 9; c++) begin
            nxt();
            bus.I_VID_REQ = c < 8;
            bus.I_VID_A = 10'h100;
            ta = 10'(16 + c);
            td = 8'(128 + c);
            push_dma(c < 5, ta, td);
            if (c < 5) wr_q.push_back({ta, td});
            if (c == 0) repeat (3) vid_q.push_back(8'h33);
            #2;
            chk("vd_lvl", 32'(bus.O_FIFO_LVL), lvl_exp[c]);
            chk("vd_ack", 32'(bus.O_VID_ACK), ack_exp[c]);
            chk("vd_we", 32'(bus.O_RAM_WE), we_exp[c]);
            if (bus.O_VID_ACK) chk("vd_vidd", 32'(bus.O_VID_D), 32'(vid_q.pop_front()));
        end
        chk("vd_ovf", 32'(bus.O_OVF), 0);
        chk("vd_q_empty", 32'(vid_q.size()), 0);
        repeat (3) nxt();
        while (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            chk("vd_dma_mem", 32'(mem[e[17:8]]), 32'(e[7:0]));
        end

        // raise the level to the high watermark, then make the CPU write wait it out
        n = 0;
        do begin
            nxt();
            bus.I_VID_REQ = 1'b1;
            push_dma(1'b1, 10'h300, 8'(n));
            #2;
            n++;
        end while (bus.O_FIFO_LVL < 3 && n < 30);
        chk("hw_fill_lvl", 32'(bus.O_FIFO_LVL), 3);
        nxt();
        bus.I_VID_REQ = 1'b0;
        for (int w = 0; w <= 10; w++) begin
            nxt();
            push_dma(1'b1, 10'h300, 8'(w));
            if (w == 0) begin
                bus.I_CPU_RQ_n = 1'b0;
                bus.I_CPU_WR_n = 1'b0;
                bus.I_CPU_A = 10'h3F0;
                bus.I_CPU_D = 8'hA5;
            end
            #2;
            if (w <= 8) chk("hw_wait_low", 32'(bus.O_WAIT_n), 0);
            if (w == 9) begin
                chk("hw_wait_hi", 32'(bus.O_WAIT_n), 1);
                chk("hw_we", 32'(bus.O_RAM_WE), 1);
                chk("hw_a", 32'(bus.O_RAM_A), 32'h3F0);
                chk("hw_d", 32'(bus.O_RAM_D), 32'hA5);
                chk("hw_lvl_full", 32'(bus.O_FIFO_LVL), 4);
            end
            if (w == 10) begin
                chk("full_pushpop_lvl", 32'(bus.O_FIFO_LVL), 4);
                chk("full_pushpop_ovf", 32'(bus.O_OVF), 0);
                chk("hw_mem", 32'(mem[10'h3F0]), 32'hA5);
            end
        end

        // push into a full FIFO while video owns the slot
        nxt();
        bus.I_VID_REQ = 1'b1;
        bus.I_CPU_RQ_n = 1'b1;
        bus.I_CPU_WR_n = 1'b1;
        push_dma(1'b1, 10'h300, 8'hEE);
        #2;
        chk("ovf_pre_lvl", 32'(bus.O_FIFO_LVL), 4);
        chk("ovf_pre", 32'(bus.O_OVF), 0);
        nxt();
        push_dma(1'b0, '0, '0);
        #2;
        chk("ovf_set", 32'(bus.O_OVF), 1);
        chk("ovf_lvl", 32'(bus.O_FIFO_LVL), 4);
        nxt();
        bus.I_VID_REQ = 1'b0;
        repeat (6) nxt();
        #2;
        chk("drain_lvl", 32'(bus.O_FIFO_LVL), 0);
        chk("ovf_sticky", 32'(bus.O_OVF), 1);

        // reset while a CPU read is in flight
        nxt();
        bus.I_CPU_RQ_n = 1'b0;
        bus.I_CPU_RD_n = 1'b0;
        bus.I_CPU_A = 10'h012;
        push_dma(1'b1, 10'h310, 8'h11);
        #2;
        chk("rr_wait_c0", 32'(bus.O_WAIT_n), 0);
        nxt();
        push_dma(1'b0, '0, '0);
        chk("rr_ce_c1", 32'(bus.O_RAM_CE), 1);
        chk("rr_lvl_c1", 32'(bus.O_FIFO_LVL), 1);
        rst_n = 1'b0;
        #1;
        chk("rr_wait_rst", 32'(bus.O_WAIT_n), 1);
        chk("rr_lvl_rst", 32'(bus.O_FIFO_LVL), 0);
        chk("rr_ovf_rst", 32'(bus.O_OVF), 0);
        chk("rr_ce_rst", 32'(bus.O_RAM_CE), 0);
        nxt();
        #2;
        chk("rr_ack", 32'(bus.O_VID_ACK), 0);
        chk("rr_cpud", 32'(bus.O_CPU_D), 0);
        chk("rr_ce_next", 32'(bus.O_RAM_CE), 0);
        chk("rr_wait_next", 32'(bus.O_WAIT_n), 1);
        nxt();
        bus.I_CPU_RQ_n = 1'b1;
        bus.I_CPU_RD_n = 1'b1;
        rst_n = 1'b1;
        repeat (3) nxt();
        chk("rr_cpud_after", 32'(bus.O_CPU_D), 0);
        chk("rr_ack_after", 32'(bus.O_VID_ACK), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
